// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix frame loader.
//   ROWS / ROW_W   : matrix geometry (8 rows of 8 pixels)
//   ADDR_W         : width of the bus-side register address
//   CTRL_ADDR      : address of the control register
//   CTRL_*_BIT     : bit positions inside the control register
//   swap_state_e   : states of the commit/swap controller
package matrix_pkg;

  localparam int ROWS   = 8;
  localparam int ROW_W  = 8;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] CTRL_ADDR = 4'h8;

  localparam int CTRL_OE_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/frame_swap_ctl.sv
// Commit/swap controller for the double-buffered frame store.
// A commit arms the controller; the next frame_sync fires a one-cycle swap.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high
//   commit     : request to publish the shadow buffer
//   frame_sync : frame-boundary pulse
//   busy       : high while a commit is waiting for a frame boundary
//   swap       : one-cycle pulse; the active buffer loads the shadow on this edge
module frame_swap_ctl
  import matrix_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic commit,
  input  logic frame_sync,
  output logic busy,
  output logic swap
);

  swap_state_e state;
  swap_state_e state_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Commits seen while pending (including one coincident with the swap)
  // are absorbed: only one swap results and the controller returns to IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    swap      = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        busy = 1'b1;
        if (frame_sync) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/matrix_frame_loader.sv
// Double-buffered frame store feeding the 8x8 LED matrix row-scan driver.
// The bus writes rows into a shadow buffer; a commit copies the shadow into
// the active buffer on the next frame boundary so the image never tears.
//   clock, reset       : system clock; asynchronous active-high reset
//   wr_en/addr/data    : bus write (0-7 shadow rows, CTRL_ADDR control)
//   rd_addr, rd_data   : registered readback, one cycle latency
//   commit, frame_sync : publish request and frame-boundary pulse
//   busy               : commit pending
//   data               : active image, row n at data[8n+7:8n]
//   oe                 : driver output enable (control bit 0)
module matrix_frame_loader #(
  parameter int                                ROWS      = matrix_pkg::ROWS,
  parameter logic [matrix_pkg::ADDR_W-1:0]     CTRL_ADDR = matrix_pkg::CTRL_ADDR
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 wr_en,
  input  logic [matrix_pkg::ADDR_W-1:0]        wr_addr,
  input  logic [matrix_pkg::ROW_W-1:0]         wr_data,
  input  logic [matrix_pkg::ADDR_W-1:0]        rd_addr,
  output logic [matrix_pkg::ROW_W-1:0]         rd_data,
  input  logic                                 commit,
  input  logic                                 frame_sync,
  output logic                                 busy,
  output logic [ROWS*matrix_pkg::ROW_W-1:0]    data,
  output logic                                 oe
);

  import matrix_pkg::*;

  localparam int RIDX_W = $clog2(ROWS);

  // Packed so that row n naturally sits at bits [8n+7:8n] of the image.
  logic [ROWS-1:0][ROW_W-1:0] shadow;
  logic [ROWS-1:0][ROW_W-1:0] active;
  logic                       enable;
  logic                       swap;
  logic                       row_wr;
  logic                       ctrl_wr;
  logic                       clr;
  logic [ROW_W-1:0]           rd_mux;

  frame_swap_ctl u_swap_ctl (
    .clock      (clock),
    .reset      (reset),
    .commit     (commit),
    .frame_sync (frame_sync),
    .busy       (busy),
    .swap       (swap)
  );

  assign row_wr  = wr_en && (int'(wr_addr) < ROWS);
  assign ctrl_wr = wr_en && (wr_addr == CTRL_ADDR);
  assign clr     = ctrl_wr && wr_data[CTRL_CLR_BIT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (clr) begin
      shadow <= '0;
    end else if (row_wr) begin
      shadow[wr_addr[RIDX_W-1:0]] <= wr_data;
    end
  end

  // Non-blocking copy takes the shadow as it stood before this edge, so a
  // write or clear in the swap cycle only affects the shadow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active <= '0;
    end else if (swap) begin
      active <= shadow;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= wr_data[CTRL_OE_BIT];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (int'(rd_addr) < ROWS) begin
      rd_mux = shadow[rd_addr[RIDX_W-1:0]];
    end else if (rd_addr == CTRL_ADDR) begin
      rd_mux = {{(ROW_W-1){1'b0}}, enable};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_mux;
    end
  end

  assign data = active;
  assign oe   = enable;

endmodule
